// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the multi-cycle multiplier and divider units of the
// MIPS datapath and owns the architectural HI/LO registers.
//
// Ports:
//   clock, reset           system clock; synchronous active-low reset
//   start_mult, start_div  one-cycle operation requests from main control
//   op_a, op_b             operands (rs, rt), latched onto unit_a/unit_b on accept
//   mthi, mtlo, wr_data    direct HI/LO writes
//   hilo_rd                MFHI/MFLO in progress (only affects stall)
//   abort                  flush the in-flight operation
//   mult_reset, div_reset  active-high unit resets; a unit runs only while its reset is low
//   unit_a, unit_b         latched operands shared by both units
//   mult_hi/lo, div_hi/lo  unit results, sampled on the capture edge
//   hi, lo                 architectural HI/LO
//   busy                   operation in flight
//   done                   one-cycle pulse after HI/LO were loaded from a unit
//   div_zero               one-cycle pulse after a DIV by zero was rejected
//   stall                  combinational: a request arrived while busy
module muldiv_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 33,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned CNT_W       = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             hilo_rd,
  input  logic             abort,
  output logic             mult_reset,
  output logic             div_reset,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RUN     = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   unit_a_q, unit_a_d;
  logic [WIDTH-1:0]   unit_b_q, unit_b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic               mult_reset_q, mult_reset_d;
  logic               div_reset_q, div_reset_d;
  logic [CNT_W-1:0]   run_last;
  logic               unit_running;

  // Last RUN count for the selected unit.
  assign run_last = (op_q == OP_MULT) ? MULT_LAST : DIV_LAST;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    unit_a_d     = unit_a_q;
    unit_b_d     = unit_b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    div_zero_d   = 1'b0;
    unit_running = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start_mult wins; a simultaneous start_div is dropped silently.
        if (start_mult) begin
          unit_a_d = op_a;
          unit_b_d = op_b;
          op_d     = OP_MULT;
          state_d  = S_LOAD;
        end else if (start_div) begin
          if (op_b != '0) begin
            unit_a_d = op_a;
            unit_b_d = op_b;
            op_d     = OP_DIV;
            state_d  = S_LOAD;
          end else begin
            div_zero_d = 1'b1;
          end
        end
        // Direct writes are honoured alongside an accepted start.
        if (mthi) hi_d = wr_data;
        if (mtlo) lo_d = wr_data;
      end

      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == run_last) state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        if (op_q == OP_MULT) begin
          hi_d = mult_hi;
          lo_d = mult_lo;
        end else begin
          hi_d = div_hi;
          lo_d = div_lo;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort flushes any in-flight operation, including the capture itself.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    // Unit resets follow the state being entered so they are glitch-free flops.
    unit_running = (state_d == S_RUN) || (state_d == S_CAPTURE);
    busy_d       = (state_d != S_IDLE);
    mult_reset_d = !(unit_running && (op_d == OP_MULT));
    div_reset_d  = !(unit_running && (op_d == OP_DIV));
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_MULT;
      cnt_q        <= '0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      div_zero_q   <= 1'b0;
      mult_reset_q <= 1'b1;
      div_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      unit_a_q     <= unit_a_d;
      unit_b_q     <= unit_b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      div_zero_q   <= div_zero_d;
      mult_reset_q <= mult_reset_d;
      div_reset_q  <= div_reset_d;
    end
  end

  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign div_zero   = div_zero_q;
  assign mult_reset = mult_reset_q;
  assign div_reset  = div_reset_q;

  // Control unit must hold any HI/LO-related request while an operation is in flight.
  assign stall = busy_q & (start_mult | start_div | mthi | mtlo | hilo_rd);

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the multi-cycle multiplier and divider units of the multi-cycle MIPS datapath.
- Owns the architectural HI/LO registers.
- Accepts MULT/DIV/MTHI/MTLO/MFHI/MFLO requests from the main control unit and holds each unit in reset while idle.
- Releases the selected unit for a fixed number of cycles, then captures its result into HI/LO. Asserts stall to the control unit while a HI/LO access conflicts with an operation in flight.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 33, clocks the multiplier must run out of reset (1 load + 32 Booth steps)
DIV_CYCLES, 33, clocks the divider must run out of reset
CNT_W, 6, run counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low; sampled on rising clock edge
start_mult  in  1  one-cycle request: HI:LO <= op_a * op_b (signed)
start_div  in  1  one-cycle request: LO <= op_a / op_b, HI <= op_a % op_b (signed)
op_a  in  WIDTH  operand A (rs)
op_b  in  WIDTH  operand B (rt)
mthi  in  1  write wr_data to HI
mtlo  in  1  write wr_data to LO
wr_data  in  WIDTH  data for mthi/mtlo
hilo_rd  in  1  control unit is reading HI or LO this cycle (MFHI/MFLO)
abort  in  1  flush in-flight operation (exception taken)
mult_reset  out  1  active-high reset to multiplier unit
div_reset  out  1  active-high reset to divider unit
unit_a  out  WIDTH  latched operand A to both units
unit_b  out  WIDTH  latched operand B to both units
mult_hi  in  WIDTH  multiplier high result
mult_lo  in  WIDTH  multiplier low result
div_hi  in  WIDTH  divider remainder
div_lo  in  WIDTH  divider quotient
hi  out  WIDTH  architectural HI register
lo  out  WIDTH  architectural LO register
busy  out  1  operation in flight
done  out  1  one-cycle pulse, HI/LO updated on the previous edge
div_zero  out  1  one-cycle pulse, DIV with op_b == 0 rejected
stall  out  1  combinational: busy & (start_mult | start_div | mthi | mtlo | hilo_rd)

Behaviour:
- Reset (reset==0 at edge): state=IDLE, hi=lo=0, unit_a=unit_b=0, cnt=0, busy=done=div_zero=0, mult_reset=div_reset=1. Reset overrides everything, including mid-run; the result is discarded.
- States:
  - IDLE: busy=0, both unit resets=1.
    - start_mult: latch op_a/op_b into unit_a/unit_b, op=MULT, go to LOAD.
    - start_div with op_b!=0: latch operands, op=DIV, go to LOAD.
    - start_div with op_b==0: div_zero=1 next cycle, HI/LO unchanged, stay IDLE.
    - Priority: start_mult over start_div if both are high; the div request is dropped, and no div_zero is raised for it.
    - mthi/mtlo: write hi/lo from wr_data at the edge. Both may be set in one cycle. They are honoured even in the same cycle as a start, and the start still proceeds.
  - LOAD (1 cycle): busy=1, resets still 1; operands are stable at the units; cnt<=0; go to RUN.
  - RUN: the selected unit's reset=0, the other unit's reset=1; cnt increments each edge. When cnt==N-1 (N=MULT_CYCLES or DIV_CYCLES by op), go to CAPTURE.
  - CAPTURE (1 cycle): busy=1, the selected unit's reset stays 0 so its outputs hold. At the edge, hi/lo are loaded from the selected unit and done<=1; go to IDLE, where both resets return to 1.
- Latency: a start sampled at edge E0 gives done=1 in the cycle after edge E0+N+2. Default is 35 edges. The next start is accepted in the same cycle that done is high.
- While busy: start_mult, start_div, mthi, mtlo and hilo_rd are not acted on. stall is asserted, and the control unit holds its request until stall drops.
  - hilo_rd with busy=0 never stalls, including the done cycle.
- abort in LOAD/RUN/CAPTURE: go to IDLE at the edge, resets=1, HI/LO unchanged, no done. abort in IDLE has no effect.
- abort and reset have priority over every transition. An abort coinciding with CAPTURE suppresses the capture.
- done and div_zero are registered one-cycle pulses, never high together.
- hi/lo change only on capture, on mthi/mtlo, or on reset.

Test Plan:
- Reset then start_mult op_a=7, op_b=0xFFFFFFFD (-3) -> busy=1 for 35 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB; mult_reset low exactly 34 cycles.
- start_div op_a=100, op_b=7 with divider model -> lo=14, hi=2 after 35 edges. Then start_div op_b=0 -> div_zero pulse next cycle, busy stays 0, hi/lo unchanged.
- mthi wr_data=0x12345678 in IDLE -> hi updates next edge. mtlo with busy=1 -> stall=1, lo unchanged until the retried write after done.
- start_mult and start_div in the same cycle, op_b=0 -> multiply runs, no div_zero. hilo_rd during RUN -> stall=1; hilo_rd in the done cycle -> stall=0.
- abort at RUN cnt=10 -> IDLE next edge, resets=1, no done, hi/lo keep prior values. New start_mult is accepted immediately and completes normally.
- reset driven low at RUN cnt=20 for one cycle -> all outputs at reset values next edge, hi=lo=0, no done pulse afterwards.
